// File: rtl/vote_collector.sv
// Serial ballot collector feeding the n-input majority voter.
// Optional popcount/tie outputs are built when VOTE_TALLY_EN is defined.
module vote_collector #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_x,
    output logic [7:0]    frame_cnt
`ifdef VOTE_TALLY_EN
    ,
    output logic [CW-1:0] out_ones,
    output logic          out_tie
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [N-2:0]   sbuf_q, sbuf_d;
    logic [N-1:0]   x_q, x_d;
    logic           valid_q, valid_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [N-1:0]   shifted;
    logic           accept;

`ifdef VOTE_TALLY_EN
    logic [CW-1:0]  ones_q, ones_d;
    logic [CW-1:0]  oones_q, oones_d;
    logic           tie_q, tie_d;
    logic [CW-1:0]  ones_sum;
`endif

    // in_ready depends only on state and rst, never on in_valid/in_bit
    assign in_ready  = (state_q == COLLECT) && !rst;
    assign accept    = in_valid && in_ready;
    assign shifted   = {sbuf_q, in_bit};
    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign frame_cnt = cnt_q;
`ifdef VOTE_TALLY_EN
    assign ones_sum  = ones_q + CW'(in_bit);
    assign out_ones  = oones_q;
    assign out_tie   = tie_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sbuf_d  = sbuf_q;
        x_d     = x_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
`ifdef VOTE_TALLY_EN
        ones_d  = ones_q;
        oones_d = oones_q;
        tie_d   = tie_q;
`endif
        unique case (state_q)
            COLLECT: begin
                // flush beats a coincident accept
                if (flush) begin
                    idx_d  = '0;
                    sbuf_d = '0;
`ifdef VOTE_TALLY_EN
                    ones_d = '0;
`endif
                end else if (accept) begin
                    sbuf_d = shifted[N-2:0];
                    if (idx_q == CW'(N - 1)) begin
                        x_d     = shifted;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        state_d = FULL;
`ifdef VOTE_TALLY_EN
                        oones_d = ones_sum;
                        tie_d   = (2 * int'(ones_sum) == N);
                        ones_d  = '0;
`endif
                    end else begin
                        idx_d  = idx_q + 1'b1;
`ifdef VOTE_TALLY_EN
                        ones_d = ones_sum;
`endif
                    end
                end
            end
            FULL: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            sbuf_q  <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
`ifdef VOTE_TALLY_EN
            ones_q  <= '0;
            oones_q <= '0;
            tie_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sbuf_q  <= sbuf_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
`ifdef VOTE_TALLY_EN
            ones_q  <= ones_d;
            oones_q <= oones_d;
            tie_q   <= tie_d;
`endif
        end
    end

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: directed plan steps plus random traffic
// checked against a queue-based ballot model.
module tb_vote_collector;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic         clk = 1'b0;
    logic         rst, in_valid, in_bit, in_ready, flush;
    logic         out_valid, out_ready;
    logic [N-1:0] out_x;
    logic [7:0]   frame_cnt;
`ifdef VOTE_TALLY_EN
    logic [CW-1:0] out_ones;
    logic          out_tie;
`endif

    int checks   = 0;
    int failures = 0;

    // model: collected ballots, completed frame, transfer count
    bit           mq[$];
    bit           m_full;
    logic [N-1:0] m_x;
    int           m_cnt;
    int           m_ones;
    bit           m_tie;

    always #5 clk = ~clk;

    vote_collector #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .frame_cnt(frame_cnt)
`ifdef VOTE_TALLY_EN
        , .out_ones(out_ones), .out_tie(out_tie)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit v, input bit b, input bit f,
                         input bit r, input bit rs);
        if (rs) begin
            mq.delete();
            m_full = 0; m_x = '0; m_cnt = 0; m_ones = 0; m_tie = 0;
        end else if (!m_full) begin
            if (f) mq.delete();
            else if (v) begin
                mq.push_back(b);
                if (mq.size() == N) begin
                    m_ones = 0;
                    for (int i = 0; i < N; i++) begin
                        m_x[N-1-i] = mq[i];
                        m_ones += int'(mq[i]);
                    end
                    m_tie  = (2 * m_ones == N);
                    m_full = 1;
                    mq.delete();
                end
            end
        end else if (r) begin
            m_full = 0;
            m_cnt  = (m_cnt + 1) % 256;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit f,
                        input bit r, input bit rs);
        in_valid  = v; in_bit = b; flush = f;
        out_ready = r; rst = rs;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!rs && !m_full));
        @(posedge clk);
        model(v, b, f, r, rs);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_x", 32'(out_x), 32'(m_x));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`ifdef VOTE_TALLY_EN
        chk("out_ones", 32'(out_ones), 32'(m_ones));
        chk("out_tie", 32'(out_tie), 32'(m_tie));
`endif
    endtask

    task automatic feed(input logic [N-1:0] bits, input bit r);
        for (int i = N - 1; i >= 0; i--) step(1, bits[i], 0, r, 0);
    endtask

    initial begin
        m_full = 0; m_x = '0; m_cnt = 0; m_ones = 0; m_tie = 0;
        // reset with in_valid held high
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("rst_x", 32'(out_x), 32'h0);
        chk("rst_cnt", 32'(frame_cnt), 32'h0);
        step(0, 0, 0, 0, 0);
        // F0 frame, downstream ready
        feed(8'hF0, 1);
        chk("f0_valid", 32'(out_valid), 32'h1);
        chk("f0_x", 32'(out_x), 32'hF0);
`ifdef VOTE_TALLY_EN
        chk("f0_ones", 32'(out_ones), 32'd4);
        chk("f0_tie", 32'(out_tie), 32'h1);
`endif
        step(0, 0, 0, 1, 0);
        chk("f0_cnt", 32'(frame_cnt), 32'h1);
        step(0, 0, 0, 1, 0);
        // 0F frame with downstream stall
        feed(8'h0F, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        chk("stall_x", 32'(out_x), 32'h0F);
        step(1, 1, 0, 1, 0);
        chk("stall_cnt", 32'(frame_cnt), 32'h2);
        feed(8'h5C, 1);
        chk("fresh_x", 32'(out_x), 32'h5C);
        step(0, 0, 0, 1, 0);
        // flush of a partial frame, then flush in FULL
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        feed(8'hAA, 0);
        chk("flush_x", 32'(out_x), 32'hAA);
        step(1, 0, 1, 0, 0);
        chk("fullflush_x", 32'(out_x), 32'hAA);
        chk("fullflush_v", 32'(out_valid), 32'h1);
        step(0, 0, 0, 1, 0);
        // gapped ones
        for (int i = 0; i < N; i++) begin
            step(0, 0, 0, 0, 0);
            step(1, 1, 0, 0, 0);
        end
        chk("gap_x", 32'(out_x), 32'hFF);
`ifdef VOTE_TALLY_EN
        chk("gap_ones", 32'(out_ones), 32'd8);
        chk("gap_tie", 32'(out_tie), 32'h0);
`endif
        step(0, 0, 0, 1, 0);
        // reset mid-frame
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("midrst_v", 32'(out_valid), 32'h0);
        feed(8'h00, 0);
        chk("zero_x", 32'(out_x), 32'h00);
        chk("zero_v", 32'(out_valid), 32'h1);
        // 256 frames wrap the counter
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 256; k++) begin
            feed(N'($urandom), 1);
            step(0, 0, 0, 1, 0);
            if (k == 0) chk("wrap_first", 32'(frame_cnt), 32'h1);
        end
        chk("wrap_cnt", 32'(frame_cnt), 32'h0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
